// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book command/response types and classification helper
//
// Provides opcode_t, status_t, cmd_t, rsp_t, cmd_class_t, UID_RESERVED and
// classify(), which maps a command to Forward / Drop / Reject.
package ob_pkg;

  typedef enum logic [3:0] {
    Op_Nop       = 4'd0,
    Op_QryBidAsk = 4'd1,
    Op_Buy       = 4'd2,
    Op_Sell      = 4'd3,
    Op_Cancel    = 4'd4
  } opcode_t;

  typedef enum logic [1:0] {
    S_Ok     = 2'd0,
    S_Reject = 2'd1
  } status_t;

  typedef struct packed {
    logic [31:0] uid;
    opcode_t     opcode;
    logic [31:0] price;
    logic [31:0] quantity;
  } cmd_t;

  typedef struct packed {
    logic [31:0] uid;
    status_t     status;
    logic [31:0] result;
  } rsp_t;

  typedef enum logic [1:0] {
    CLS_Fwd    = 2'd0,
    CLS_Drop   = 2'd1,
    CLS_Reject = 2'd2
  } cmd_class_t;

  localparam logic [31:0] UID_RESERVED = '1;

  // Nop is checked first: a Nop is silently dropped even with a reserved uid.
  function automatic cmd_class_t classify(input cmd_t c);
    cmd_class_t cls;
    cls = CLS_Fwd;
    if (c.opcode == Op_Nop) begin
      cls = CLS_Drop;
    end else if ((c.uid == UID_RESERVED) ||
                 (c.opcode < Op_QryBidAsk) || (c.opcode > Op_Cancel) ||
                 (((c.opcode == Op_Buy) || (c.opcode == Op_Sell)) &&
                  (c.quantity == 32'd0))) begin
      cls = CLS_Reject;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ob_cmd_fifo.sv
// rtl/ob_cmd_fifo.sv - synchronous FIFO with valid/ready on both sides
//
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   s_tdata/tvalid/tready write side (tready = not full, no bypass when full)
//   m_tdata/tvalid/tready read side (m_tdata = head entry, stable until popped)
//   count                 number of stored entries, 0..DEPTH
module ob_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [WIDTH-1:0]         s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB: equal low bits with differing MSB means full.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset; the head is only observed while m_tvalid is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

endmodule

// File: rtl/ob_cmd_ingress.sv
// rtl/ob_cmd_ingress.sv - command ingress: classify, buffer forwards, hold one reject
//
// Optional feature macro: OB_CMD_INGRESS_STATS_EN adds stat_fwd/stat_drop/stat_rej.
// Ports:
//   clk, arst_n                      clock, asynchronous active-low reset
//   cmd_vld, cmd, cmd_accept         upstream command handshake
//   core_vld, core_cmd, core_accept  FIFO head towards the order-book core
//   rej_vld, rej_rsp, rej_accept     single-entry reject response slot
//   occupancy                        buffered command count
//   stat_fwd, stat_drop, stat_rej    saturating acceptance counters (optional)
module ob_cmd_ingress
  import ob_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          cmd_vld,
  input  cmd_t                          cmd,
  output logic                          cmd_accept,
  output logic                          core_vld,
  output cmd_t                          core_cmd,
  input  logic                          core_accept,
  output logic                          rej_vld,
  output rsp_t                          rej_rsp,
  input  logic                          rej_accept,
`ifdef OB_CMD_INGRESS_STATS_EN
  output logic [31:0]                   stat_fwd,
  output logic [31:0]                   stat_drop,
  output logic [31:0]                   stat_rej,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  typedef enum logic {
    REJ_IDLE    = 1'b0,
    REJ_PENDING = 1'b1
  } rej_state_t;

  rej_state_t rej_state;
  logic       run_q;
  logic       fifo_ready;
  logic       take;
  logic       fwd_push;
  cmd_class_t cls;

  // run_q keeps cmd_accept low while reset is held and until the first edge
  // after release; cmd contents never feed cmd_accept.
  assign cmd_accept = run_q && fifo_ready && !rej_vld;
  assign take       = cmd_vld && cmd_accept;
  assign cls        = classify(cmd);
  assign fwd_push   = take && (cls == CLS_Fwd);

  ob_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .s_tdata  (cmd),
    .s_tvalid (fwd_push),
    .s_tready (fifo_ready),
    .m_tdata  (core_cmd),
    .m_tvalid (core_vld),
    .m_tready (core_accept),
    .count    (occupancy)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run_q     <= 1'b0;
      rej_state <= REJ_IDLE;
      rej_vld   <= 1'b0;
      rej_rsp   <= '0;
    end else begin
      run_q <= 1'b1;
      case (rej_state)
        REJ_IDLE: begin
          if (take && (cls == CLS_Reject)) begin
            rej_state      <= REJ_PENDING;
            rej_vld        <= 1'b1;
            rej_rsp.uid    <= cmd.uid;
            rej_rsp.status <= S_Reject;
            rej_rsp.result <= '0;
          end
        end
        REJ_PENDING: begin
          if (rej_accept) begin
            rej_state <= REJ_IDLE;
            rej_vld   <= 1'b0;
          end
        end
        default: begin
          rej_state <= REJ_IDLE;
          rej_vld   <= 1'b0;
        end
      endcase
    end
  end

`ifdef OB_CMD_INGRESS_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_fwd  <= '0;
      stat_drop <= '0;
      stat_rej  <= '0;
    end else if (take) begin
      case (cls)
        CLS_Fwd:    stat_fwd  <= sat_inc(stat_fwd);
        CLS_Drop:   stat_drop <= sat_inc(stat_drop);
        CLS_Reject: stat_rej  <= sat_inc(stat_rej);
        default:    ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ob_cmd_ingress.sv
// tb/tb_ob_cmd_ingress.sv - directed self-checking bench for ob_cmd_ingress
module tb_ob_cmd_ingress;
  import ob_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       cmd_vld = 1'b0;
  cmd_t       cmd = '0;
  logic       cmd_accept;
  logic       core_vld;
  cmd_t       core_cmd;
  logic       core_accept = 1'b0;
  logic       rej_vld;
  rsp_t       rej_rsp;
  logic       rej_accept = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef OB_CMD_INGRESS_STATS_EN
  logic [31:0] stat_fwd;
  logic [31:0] stat_drop;
  logic [31:0] stat_rej;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ob_cmd_ingress #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_vld     (cmd_vld),
    .cmd         (cmd),
    .cmd_accept  (cmd_accept),
    .core_vld    (core_vld),
    .core_cmd    (core_cmd),
    .core_accept (core_accept),
    .rej_vld     (rej_vld),
    .rej_rsp     (rej_rsp),
    .rej_accept  (rej_accept),
`ifdef OB_CMD_INGRESS_STATS_EN
    .stat_fwd    (stat_fwd),
    .stat_drop   (stat_drop),
    .stat_rej    (stat_rej),
`endif
    .occupancy   (occupancy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [31:0] uid, input logic [3:0] op,
                              input logic [31:0] price, input logic [31:0] qty);
    cmd_t c;
    c.uid      = uid;
    c.opcode   = opcode_t'(op);
    c.price    = price;
    c.quantity = qty;
    return c;
  endfunction

  function automatic rsp_t rej_of(input logic [31:0] uid);
    rsp_t r;
    r.uid    = uid;
    r.status = S_Reject;
    r.result = '0;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called on a negedge; presents c for one edge and returns on the next negedge.
  task automatic send(input cmd_t c);
    check("cmd_accept_before_send", 128'(cmd_accept), 128'(1));
    cmd_vld = 1'b1;
    cmd     = c;
    tick(1);
    cmd_vld = 1'b0;
  endtask

  task automatic rej_ack();
    rej_accept = 1'b1;
    tick(1);
    rej_accept = 1'b0;
  endtask

  cmd_t c0;

  initial begin
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    #1;
    check("rst_core_vld",   128'(core_vld),   128'(0));
    check("rst_rej_vld",    128'(rej_vld),    128'(0));
    check("rst_cmd_accept", 128'(cmd_accept), 128'(0));
    check("rst_occupancy",  128'(occupancy),  128'(0));
    check("rst_rej_rsp",    128'(rej_rsp),    128'(0));
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    tick(1);
    check("post_rst_cmd_accept", 128'(cmd_accept), 128'(1));

    // Forward: Buy uid 5
    c0 = mk(32'd5, 4'd2, 32'd100, 32'd10);
    send(c0);
    check("fwd_core_vld",  128'(core_vld),  128'(1));
    check("fwd_core_cmd",  128'(core_cmd),  128'(c0));
    check("fwd_occupancy", 128'(occupancy), 128'(1));
    check("fwd_rej_vld",   128'(rej_vld),   128'(0));
    core_accept = 1'b1;
    tick(1);
    core_accept = 1'b0;
    check("pop_core_vld",  128'(core_vld),  128'(0));
    check("pop_occupancy", 128'(occupancy), 128'(0));

    // Reserved uid reject
    send(mk(32'hFFFF_FFFF, 4'd3, 32'd50, 32'd5));
    check("rsv_rej_vld",    128'(rej_vld),    128'(1));
    check("rsv_rej_rsp",    128'(rej_rsp),    128'(rej_of(32'hFFFF_FFFF)));
    check("rsv_cmd_accept", 128'(cmd_accept), 128'(0));
    check("rsv_core_vld",   128'(core_vld),   128'(0));
    cmd_vld = 1'b1;
    cmd     = mk(32'd99, 4'd2, 32'd1, 32'd1);
    tick(2);
    cmd_vld = 1'b0;
    check("rsv_hold_cmd_accept", 128'(cmd_accept), 128'(0));
    check("rsv_hold_rej_rsp",    128'(rej_rsp),    128'(rej_of(32'hFFFF_FFFF)));
    check("rsv_hold_occupancy",  128'(occupancy),  128'(0));
    rej_ack();
    check("rsv_ack_rej_vld",    128'(rej_vld),    128'(0));
    check("rsv_ack_cmd_accept", 128'(cmd_accept), 128'(1));

    // Nop dropped
    send(mk(32'd7, 4'd0, 32'd0, 32'd0));
    check("nop_core_vld",  128'(core_vld),  128'(0));
    check("nop_rej_vld",   128'(rej_vld),   128'(0));
    check("nop_occupancy", 128'(occupancy), 128'(0));

    // Out-of-range opcode then zero-quantity Buy
    send(mk(32'd11, 4'b1001, 32'd1, 32'd1));
    check("badop_rej_vld", 128'(rej_vld), 128'(1));
    check("badop_rej_rsp", 128'(rej_rsp), 128'(rej_of(32'd11)));
    rej_ack();
    send(mk(32'd12, 4'd2, 32'd1, 32'd0));
    check("qty0_rej_vld",  128'(rej_vld),   128'(1));
    check("qty0_rej_rsp",  128'(rej_rsp),   128'(rej_of(32'd12)));
    check("qty0_core_vld", 128'(core_vld),  128'(0));
    rej_ack();
    check("qty0_occupancy", 128'(occupancy), 128'(0));

    // Fill to DEPTH, then drain while fifth waits
    for (int i = 0; i < 4; i++) send(mk(32'd20 + 32'(i), 4'd2, 32'd10, 32'd1));
    check("full_occupancy",  128'(occupancy),    128'(4));
    check("full_cmd_accept", 128'(cmd_accept),   128'(0));
    check("full_head",       128'(core_cmd.uid), 128'(20));
    cmd_vld     = 1'b1;
    cmd         = mk(32'd24, 4'd3, 32'd10, 32'd1);
    core_accept = 1'b1;
    tick(1);
    check("drain1_occupancy",  128'(occupancy),    128'(3));
    check("drain1_cmd_accept", 128'(cmd_accept),   128'(1));
    check("drain1_head",       128'(core_cmd.uid), 128'(21));
    tick(1);
    cmd_vld = 1'b0;
    check("drain2_occupancy", 128'(occupancy),    128'(3));
    check("drain2_head",      128'(core_cmd.uid), 128'(22));
    tick(1);
    check("drain3_head", 128'(core_cmd.uid), 128'(23));
    tick(1);
    check("drain4_head",      128'(core_cmd.uid), 128'(24));
    check("drain4_occupancy", 128'(occupancy),    128'(1));
    tick(1);
    core_accept = 1'b0;
    check("drained_core_vld",  128'(core_vld),  128'(0));
    check("drained_occupancy", 128'(occupancy), 128'(0));

    // Mid-operation reset with buffered commands and a pending reject
    for (int i = 0; i < 3; i++) send(mk(32'd40 + 32'(i), 4'd2, 32'd5, 32'd2));
    send(mk(32'hFFFF_FFFF, 4'd2, 32'd5, 32'd2));
    check("pre_rst_occupancy", 128'(occupancy), 128'(3));
    check("pre_rst_rej_vld",   128'(rej_vld),   128'(1));
    arst_n = 1'b0;
    #1;
    check("mid_rst_core_vld",   128'(core_vld),   128'(0));
    check("mid_rst_rej_vld",    128'(rej_vld),    128'(0));
    check("mid_rst_occupancy",  128'(occupancy),  128'(0));
    check("mid_rst_cmd_accept", 128'(cmd_accept), 128'(0));
    @(negedge clk);
    arst_n = 1'b1;
    tick(1);
    check("rel_cmd_accept", 128'(cmd_accept), 128'(1));
    check("rel_core_vld",   128'(core_vld),   128'(0));
    check("rel_rej_vld",    128'(rej_vld),    128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
